// File: rtl/dram_arb_pkg.sv
// Shared state encoding and grant constants for the two-requester DRAM read arbiter.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StBusy  = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] Grant0    = 2'b01;
    localparam logic [1:0] Grant1    = 2'b10;

    function automatic logic [1:0] owner_grant(input logic owner);
        return owner ? Grant1 : Grant0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin selector: on a tie the requester that did not own last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       valid_o,
    output logic       owner_o
);

    always_comb begin
        valid_o = |req_i;
        owner_o = 1'b0;
        case (req_i)
            2'b01:   owner_o = 1'b0;
            2'b10:   owner_o = 1'b1;
            2'b11:   owner_o = ~last_owner_i;
            default: owner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dram_rd_arbiter.sv
// Arbitrates two read requesters onto one DRAM reader and routes returned beats to the owner.
module dram_rd_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned BEAT_W = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0_kick,
    input  logic [DW-1:0] req0_addr,
    input  logic [DW-1:0] req0_num,
    output logic          req0_busy,
    output logic [DW-1:0] req0_dout,
    output logic          req0_we,
    input  logic          req1_kick,
    input  logic [DW-1:0] req1_addr,
    input  logic [DW-1:0] req1_num,
    output logic          req1_busy,
    output logic [DW-1:0] req1_dout,
    output logic          req1_we,
    output logic          dram_kick,
    input  logic          dram_busy,
    output logic [DW-1:0] dram_addr,
    output logic [DW-1:0] dram_num,
    input  logic [DW-1:0] dram_dout,
    input  logic          dram_we,
    output logic [1:0]    grant,
    output logic          beat_err
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [DW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       num_q, num_d;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                arb_valid;
    logic                arb_owner;

    rr_arb2 u_rr_arb2 (
        .req_i        ({req1_kick, req0_kick}),
        .last_owner_i (last_q),
        .valid_o      (arb_valid),
        .owner_o      (arb_owner)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        grant   = (state_q == StIdle) ? GrantNone : owner_grant(owner_q);

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    owner_d = arb_owner;
                    addr_d  = arb_owner ? req1_addr : req0_addr;
                    num_d   = arb_owner ? req1_num : req0_num;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (dram_busy) state_d = StBusy;
            end
            StBusy: begin
                if (!dram_busy) state_d = StDone;
            end
            StDone: begin
                last_d  = owner_q;
                if (cnt_q != num_q[BEAT_W-1:0]) err_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if ((state_q == StIssue || state_q == StBusy) && dram_we &&
            cnt_q != {BEAT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(BEAT_W-1){1'b0}}, 1'b1};
        end
        // Beats arriving with no owner have nowhere to go; flag them.
        if (dram_we && grant == GrantNone) err_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        dram_kick = (state_q == StIssue);
        req0_busy = (state_q == StIssue || state_q == StBusy) && !owner_q;
        req1_busy = (state_q == StIssue || state_q == StBusy) && owner_q;
        req0_we   = dram_we & grant[0];
        req1_we   = dram_we & grant[1];
        req0_dout = grant[0] ? dram_dout : '0;
        req1_dout = grant[1] ? dram_dout : '0;
        dram_addr = addr_q;
        dram_num  = num_q;
        beat_err  = err_q;
    end

endmodule
